// File: rtl/button_debouncer.sv
// Multi-channel button/switch debouncer: per-channel FSM with persistence counter,
// registered level and press/release pulses. Define BUTTON_DEBOUNCER_SYNC_EN to add a 2-flop input synchronizer.
module button_debouncer #(
  parameter int          WIDTH           = 4,
  parameter int unsigned DEBOUNCE_PERIOD = 5_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic [WIDTH-1:0] sample;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = sync2_reg;
`else
  // raw_i is trusted to already be synchronous to clk_i in this build
  assign sample = raw_i;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      state_t           state_reg;
      logic [CNT_W-1:0] count_reg;
      logic             stable_reg;
      logic             press_reg;
      logic             release_reg;
      logic             s;

      assign s = sample[gi];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_reg   <= STABLE_LOW;
          count_reg   <= '0;
          stable_reg  <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          case (state_reg)
            STABLE_LOW: begin
              if (s) begin
                state_reg <= WAIT_HIGH;
                count_reg <= CNT_ONE;
              end else begin
                count_reg <= '0;
              end
            end
            WAIT_HIGH: begin
              if (!s) begin
                state_reg <= STABLE_LOW;
                count_reg <= '0;
              end else if (count_reg == CNT_LAST) begin
                // level has persisted the full period: accept it
                state_reg  <= STABLE_HIGH;
                count_reg  <= '0;
                stable_reg <= 1'b1;
                press_reg  <= 1'b1;
              end else begin
                count_reg <= count_reg + CNT_ONE;
              end
            end
            STABLE_HIGH: begin
              if (!s) begin
                state_reg <= WAIT_LOW;
                count_reg <= CNT_ONE;
              end else begin
                count_reg <= '0;
              end
            end
            WAIT_LOW: begin
              if (s) begin
                state_reg <= STABLE_HIGH;
                count_reg <= '0;
              end else if (count_reg == CNT_LAST) begin
                state_reg   <= STABLE_LOW;
                count_reg   <= '0;
                stable_reg  <= 1'b0;
                release_reg <= 1'b1;
              end else begin
                count_reg <= count_reg + CNT_ONE;
              end
            end
            default: begin
              state_reg  <= STABLE_LOW;
              count_reg  <= '0;
              stable_reg <= 1'b0;
            end
          endcase
        end
      end

      assign stable_o[gi]  = stable_reg;
      assign press_o[gi]   = press_reg;
      assign release_o[gi] = release_reg;
    end
  endgenerate

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels (buttons or switches).
REQ-002 SHALL have parameter DEBOUNCE_PERIOD, default 5_000_000: consecutive clk_i cycles a new level must persist before acceptance; legal range 2..2^32-1.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port raw_i, input, WIDTH: raw, bouncing, clock-asynchronous button/switch levels.
REQ-006 SHALL have port stable_o, output, WIDTH: debounced level per channel, registered.
REQ-007 SHALL have port press_o, output, WIDTH: one-cycle pulse when the channel's stable_o goes 0->1, registered.
REQ-008 SHALL have port release_o, output, WIDTH: one-cycle pulse when the channel's stable_o goes 1->0, registered.

Function
REQ-009 SHALL process each channel independently, with its own FSM and counter of width $clog2(DEBOUNCE_PERIOD); channels SHALL share no state.
REQ-010 SHALL derive the per-channel sample s from raw_i through the input stage defined under Configuration.
REQ-011 SHALL implement per-channel FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW; stable_o is 1 exactly in STABLE_HIGH and WAIT_LOW.
REQ-012 STABLE_LOW with s=1 SHALL go to WAIT_HIGH with count=1; STABLE_HIGH with s=0 SHALL go to WAIT_LOW with count=1; otherwise the state holds and count=0.
REQ-013 WAIT_HIGH with s=1 SHALL increment count; when count==DEBOUNCE_PERIOD-1 it SHALL instead go to STABLE_HIGH, clear count, and assert press_o for the following cycle only.
REQ-014 WAIT_HIGH with s=0 SHALL return to STABLE_LOW with count=0 and no pulse; WAIT_LOW SHALL mirror REQ-013/014 with s inverted, release_o, STABLE_LOW and STABLE_HIGH.
REQ-015 Latency SHALL be exactly DEBOUNCE_PERIOD rising edges from the first edge sampling the new s to stable_o changing, provided s holds throughout; press_o/release_o SHALL assert in the same cycle stable_o changes.
REQ-016 Any glitch shorter than DEBOUNCE_PERIOD cycles SHALL leave stable_o, press_o and release_o unchanged; a glitch restarts the count from 1 on the next qualifying edge.
REQ-017 press_o and release_o SHALL never both be 1 on one channel; each pulse SHALL last exactly one cycle.
REQ-018 count SHALL never exceed DEBOUNCE_PERIOD-1 and SHALL never wrap.
REQ-019 Simultaneous transitions on several channels SHALL produce simultaneous pulses on those channels with no arbitration.

Reset
REQ-020 While rst_i=1, all FSMs SHALL be STABLE_LOW, all counters 0, synchronizer flops 0, and stable_o, press_o, release_o all 0, independent of clk_i.
REQ-021 Reset asserted during WAIT_HIGH/WAIT_LOW SHALL abort the wait with no pulse emitted.
REQ-022 A channel held at 1 through reset deassertion SHALL debounce to 1 per REQ-015 and emit one press_o pulse.

Configuration
REQ-023 Macro BUTTON_DEBOUNCER_SYNC_EN defined: s SHALL be raw_i passed through a 2-flop synchronizer per channel, adding 2 cycles of latency (raw change to stable_o change = DEBOUNCE_PERIOD+2 edges).
REQ-024 Macro BUTTON_DEBOUNCER_SYNC_EN undefined: s SHALL equal raw_i directly, with no synchronizer flops and latency DEBOUNCE_PERIOD edges; for use only when raw_i is already synchronous to clk_i.

Verification (DEBOUNCE_PERIOD=4, WIDTH=4, SYNC_EN defined)
REQ-025 raw_i[0] 0->1 and held -> stable_o[0]=1 and press_o[0]=1 for exactly one cycle, 6 edges after the change; other bits stay 0.
REQ-026 raw_i[1] high for 3 cycles, then low -> stable_o[1], press_o[1] and release_o[1] stay 0 throughout.
REQ-027 raw_i[2] already stable at 1, then pulsed to 0 for 2 cycles, then 0 and held -> no release_o during the glitch; release_o[2] fires once after 4 consecutive low samples.
REQ-028 raw_i=4'hF in one cycle and held -> press_o=4'hF in one cycle 6 edges later, then 4'h0.
REQ-029 rst_i asserted mid-WAIT_HIGH, asynchronously between edges -> outputs 0 immediately with no pulse; after release with raw held 1, one press_o pulse 6 edges later.
